// File: rtl/synaptic_accumulator.sv
// Per-neuron signed synaptic current accumulator with tick-triggered drain.
// Optional clamping arithmetic is enabled by defining ACCUM_SATURATION_EN.
module synaptic_accumulator #(
   parameter int NUM_NEURONS     = 64,
   parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
   parameter int WEIGHT_WIDTH    = 8,
   parameter int ACC_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_spike_valid,
   input  logic [NEURON_ID_WIDTH-1:0] s_spike_dest_id,
   input  logic [WEIGHT_WIDTH-1:0]    s_spike_weight,
   input  logic                       s_spike_exc_inh,
   output logic                       s_spike_ready,
   input  logic                       timestep_tick,
   output logic                       m_current_valid,
   output logic [NEURON_ID_WIDTH-1:0] m_current_neuron_id,
   output logic [ACC_WIDTH-1:0]       m_current_value,
   input  logic                       m_current_ready,
   output logic                       accum_busy,
   output logic [31:0]                event_count,
   output logic                       tick_overrun,
   output logic                       sat_flag
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic [NEURON_ID_WIDTH-1:0] LAST_IDX = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

   state_t                       state_q, state_d;
   logic [NEURON_ID_WIDTH-1:0]   idx_q, idx_d;
   logic [ACC_WIDTH-1:0]         acc_q [NUM_NEURONS];
   logic [ACC_WIDTH-1:0]         acc_d [NUM_NEURONS];
   logic [31:0]                  event_count_q, event_count_d;
   logic                         tick_overrun_q, tick_overrun_d;
   logic                         accept_s;
   logic                         drain_hs_s;

`ifdef ACCUM_SATURATION_EN
   logic                         sat_flag_q, sat_flag_d;
   logic [ACC_WIDTH:0]           upd_s;

   // Returns {clamped, result}; one guard bit exposes signed overflow.
   function automatic logic [ACC_WIDTH:0] acc_update(
      input logic [ACC_WIDTH-1:0]    acc,
      input logic [WEIGHT_WIDTH-1:0] w,
      input logic                    exc
   );
      logic [ACC_WIDTH:0] ext;
      logic [ACC_WIDTH:0] wext;
      logic [ACC_WIDTH:0] raw;
      ext  = {acc[ACC_WIDTH-1], acc};
      wext = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, w};
      if (exc) begin
         raw = ext + wext;
      end else begin
         raw = ext - wext;
      end
      if (raw[ACC_WIDTH] != raw[ACC_WIDTH-1]) begin
         if (raw[ACC_WIDTH]) begin
            acc_update = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
         end else begin
            acc_update = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else begin
         acc_update = {1'b0, raw[ACC_WIDTH-1:0]};
      end
   endfunction
`else
   logic [ACC_WIDTH-1:0]         upd_s;

   function automatic logic [ACC_WIDTH-1:0] acc_update(
      input logic [ACC_WIDTH-1:0]    acc,
      input logic [WEIGHT_WIDTH-1:0] w,
      input logic                    exc
   );
      logic [ACC_WIDTH-1:0] wext;
      wext = {{(ACC_WIDTH - WEIGHT_WIDTH){1'b0}}, w};
      if (exc) begin
         acc_update = acc + wext;
      end else begin
         acc_update = acc - wext;
      end
   endfunction
`endif

   assign s_spike_ready       = rst_n && (state_q == ST_ACCUM);
   assign m_current_valid     = rst_n && (state_q == ST_DRAIN);
   assign accum_busy          = m_current_valid;
   assign m_current_neuron_id = m_current_valid ? idx_q : {NEURON_ID_WIDTH{1'b0}};
   assign m_current_value     = m_current_valid ? acc_q[idx_q] : {ACC_WIDTH{1'b0}};
   assign event_count         = event_count_q;
   assign tick_overrun        = tick_overrun_q;
   assign accept_s            = s_spike_valid && s_spike_ready;
   assign drain_hs_s          = m_current_valid && m_current_ready;
`ifdef ACCUM_SATURATION_EN
   assign sat_flag            = sat_flag_q;
`else
   assign sat_flag            = 1'b0;
`endif

   // Next-state, accumulate and drain logic.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      acc_d          = acc_q;
      event_count_d  = event_count_q;
      tick_overrun_d = tick_overrun_q;
`ifdef ACCUM_SATURATION_EN
      sat_flag_d     = sat_flag_q;
      upd_s          = {(ACC_WIDTH+1){1'b0}};
`else
      upd_s          = {ACC_WIDTH{1'b0}};
`endif
      case (state_q)
         ST_ACCUM: begin
            if (accept_s) begin
               upd_s = acc_update(acc_q[s_spike_dest_id], s_spike_weight, s_spike_exc_inh);
`ifdef ACCUM_SATURATION_EN
               acc_d[s_spike_dest_id] = upd_s[ACC_WIDTH-1:0];
               sat_flag_d             = sat_flag_q | upd_s[ACC_WIDTH];
`else
               acc_d[s_spike_dest_id] = upd_s;
`endif
               event_count_d = event_count_q + 32'd1;
            end else begin
               event_count_d = event_count_q;
            end
            // A same-cycle event is folded in above before the drain starts.
            if (timestep_tick) begin
               state_d = ST_DRAIN;
               idx_d   = {NEURON_ID_WIDTH{1'b0}};
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            if (timestep_tick) begin
               tick_overrun_d = 1'b1;
            end else begin
               tick_overrun_d = tick_overrun_q;
            end
            if (drain_hs_s) begin
               acc_d[idx_q] = {ACC_WIDTH{1'b0}};
               if (idx_q == LAST_IDX) begin
                  state_d = ST_ACCUM;
                  idx_d   = {NEURON_ID_WIDTH{1'b0}};
               end else begin
                  idx_d = idx_q + NEURON_ID_WIDTH'(1);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = ST_ACCUM;
            idx_d   = {NEURON_ID_WIDTH{1'b0}};
         end
      endcase
   end

   // State, index, accumulator and status registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_ACCUM;
         idx_q          <= {NEURON_ID_WIDTH{1'b0}};
         event_count_q  <= 32'd0;
         tick_overrun_q <= 1'b0;
`ifdef ACCUM_SATURATION_EN
         sat_flag_q     <= 1'b0;
`endif
         for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_q[i] <= {ACC_WIDTH{1'b0}};
         end
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         event_count_q  <= event_count_d;
         tick_overrun_q <= tick_overrun_d;
`ifdef ACCUM_SATURATION_EN
         sat_flag_q     <= sat_flag_d;
`endif
         for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

endmodule
